// File: rtl/mem_arbiter_rr.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : mem_arbiter_rr
// Purpose  : Round-robin bus arbiter with a bounded hold time and a one-cycle
//            turnaround gap between owners.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module mem_arbiter_rr #(
   parameter int N_CH     = 2,
   parameter int MAX_HOLD = 16
) (
   input  logic                     Clk,
   input  logic                     Rst,
   input  logic [N_CH-1:0]          req,
   output logic [N_CH-1:0]          grt,
   output logic [$clog2(N_CH)-1:0]  owner,
   output logic                     busy,
   output logic                     preempt
);

   localparam int OW = $clog2(N_CH);
   localparam int HW = (MAX_HOLD > 0) ? (($clog2(MAX_HOLD + 1) > 0) ? $clog2(MAX_HOLD + 1) : 1) : 1;
   localparam logic [HW-1:0] c_HOLD_LAST = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : {HW{1'b0}};
   localparam logic [N_CH-1:0] c_ONE = {{(N_CH-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANT   = 2'd1,
      ST_RELEASE = 2'd2
   } state_t;

   state_t          r_state,   w_state;
   logic [N_CH-1:0] r_grt,     w_grt;
   logic [OW-1:0]   r_owner,   w_owner;
   logic [OW-1:0]   r_last,    w_last;
   logic [HW-1:0]   r_hold,    w_hold;
   logic            r_busy;
   logic            r_preempt, w_preempt;

   logic [OW-1:0]   w_winner;
   logic            w_any;
   logic            w_others;
   logic            w_own_req;

   // First requester found scanning upward from the channel after last_owner.
   function automatic logic [OW-1:0] rr_pick(input logic [N_CH-1:0] r,
                                             input logic [OW-1:0]   last);
      int   idx;
      logic found;
      rr_pick = last;
      found   = 1'b0;
      for (int k = 1; k <= N_CH; k++) begin
         idx = (int'(last) + k) % N_CH;
         if (!found && r[idx]) begin
            rr_pick = OW'(idx);
            found   = 1'b1;
         end
      end
   endfunction

   assign w_any     = |req;
   assign w_winner  = rr_pick(req, r_last);
   assign w_others  = |(req & ~r_grt);
   assign w_own_req = req[r_owner];

   always_comb begin
      w_state   = r_state;
      w_grt     = r_grt;
      w_owner   = r_owner;
      w_last    = r_last;
      w_hold    = r_hold;
      w_preempt = 1'b0;
      case (r_state)
         ST_IDLE, ST_RELEASE: begin
            if (w_any) begin
               w_state = ST_GRANT;
               w_grt   = c_ONE << w_winner;
               w_owner = w_winner;
               w_last  = w_winner;
               w_hold  = '0;
            end else begin
               w_state = ST_IDLE;
               w_grt   = '0;
            end
         end
         ST_GRANT: begin
            if (!w_own_req) begin
               w_state = ST_RELEASE;
               w_grt   = '0;
            end else if ((MAX_HOLD > 0) && (r_hold == c_HOLD_LAST) && w_others) begin
               w_state   = ST_RELEASE;
               w_grt     = '0;
               w_preempt = 1'b1;
            end else if ((MAX_HOLD > 0) && (r_hold != c_HOLD_LAST)) begin
               w_hold = r_hold + 1'b1;
            end
         end
         default: begin
            w_state = ST_IDLE;
            w_grt   = '0;
         end
      endcase
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_state   <= ST_IDLE;
         r_grt     <= '0;
         r_owner   <= '0;
         r_last    <= OW'(N_CH - 1);
         r_hold    <= '0;
         r_busy    <= 1'b0;
         r_preempt <= 1'b0;
      end else begin
         r_state   <= w_state;
         r_grt     <= w_grt;
         r_owner   <= w_owner;
         r_last    <= w_last;
         r_hold    <= w_hold;
         r_busy    <= |w_grt;
         r_preempt <= w_preempt;
      end
   end

   assign grt     = r_grt;
   assign owner   = r_owner;
   assign busy    = r_busy;
   assign preempt = r_preempt;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter_rr.sv
`default_nettype none
`timescale 1ns/1ps
//------------------------------------------------------------------------------
// Module   : tb_mem_arbiter_rr
// Purpose  : Directed table, corner sequences and random traffic against a
//            cycle-level reference model for two arbiter configurations.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module tb_mem_arbiter_rr;

   logic       Clk = 1'b0;
   logic       Rst;
   logic [3:0] req4, grt4;
   logic [1:0] own4;
   logic       busy4, pre4;
   logic [2:0] req3, grt3;
   logic [1:0] own3;
   logic       busy3, pre3;
   logic [3:0] prev4;
   logic [2:0] prev3;
   int         checks = 0;
   int         errors = 0;

   always #5 Clk = ~Clk;

   mem_arbiter_rr #(.N_CH(4), .MAX_HOLD(4)) u_dut4 (
      .Clk(Clk), .Rst(Rst), .req(req4), .grt(grt4),
      .owner(own4), .busy(busy4), .preempt(pre4)
   );

   mem_arbiter_rr #(.N_CH(3), .MAX_HOLD(0)) u_dut3 (
      .Clk(Clk), .Rst(Rst), .req(req3), .grt(grt3),
      .owner(own3), .busy(busy3), .preempt(pre3)
   );

   // Reference: who holds the bus, for how many cycles, and who went last.
   typedef struct {
      bit granted;
      int owner;
      int last;
      int held;
      bit pre;
   } mdl_t;

   mdl_t m4, m3;

   function automatic mdl_t mdl_reset(input int n);
      mdl_t m;
      m.granted = 1'b0;
      m.owner   = 0;
      m.last    = n - 1;
      m.held    = 0;
      m.pre     = 1'b0;
      return m;
   endfunction

   function automatic mdl_t mdl_step(input mdl_t m, input logic [7:0] r,
                                     input int n, input int mh);
      mdl_t x;
      bit   others;
      x      = m;
      x.pre  = 1'b0;
      others = (r & ~(8'd1 << m.owner)) != 8'd0;
      if (m.granted) begin
         if (!r[m.owner]) begin
            x.granted = 1'b0;
         end else if (mh > 0 && m.held >= mh && others) begin
            x.granted = 1'b0;
            x.pre     = 1'b1;
         end else begin
            x.held = m.held + 1;
         end
      end else if (r != 8'd0) begin
         for (int k = 1; k <= n; k++) begin
            if (r[(m.last + k) % n]) begin
               x.granted = 1'b1;
               x.owner   = (m.last + k) % n;
               x.last    = x.owner;
               x.held    = 1;
               break;
            end
         end
      end
      return x;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      prev4 = grt4;
      prev3 = grt3;
      @(posedge Clk);
      if (!Rst) begin
         m4 = mdl_step(m4, {4'b0, req4}, 4, 4);
         m3 = mdl_step(m3, {5'b0, req3}, 3, 0);
      end
      #1;
   endtask

   task automatic do_reset();
      Rst  = 1'b1;
      req4 = '0;
      req3 = '0;
      m4   = mdl_reset(4);
      m3   = mdl_reset(3);
      repeat (2) @(posedge Clk);
      #2 Rst = 1'b0;
   endtask

   task automatic compare_model();
      chk("m4_grt",   int'(grt4),  m4.granted ? (1 << m4.owner) : 0);
      chk("m4_owner", int'(own4),  m4.owner);
      chk("m4_busy",  int'(busy4), int'(m4.granted));
      chk("m4_pre",   int'(pre4),  int'(m4.pre));
      chk("m3_grt",   int'(grt3),  m3.granted ? (1 << m3.owner) : 0);
      chk("m3_owner", int'(own3),  m3.owner);
      chk("m3_busy",  int'(busy3), int'(m3.granted));
      chk("m3_pre",   int'(pre3),  int'(m3.pre));
      chk("onehot4",  int'($countones(grt4) <= 1), 1);
      chk("onehot3",  int'($countones(grt3) <= 1), 1);
      chk("busy_or4", int'(busy4), int'(|grt4));
      chk("b2b4",     int'(prev4 != 0 && grt4 != 0 && prev4 != grt4), 0);
      chk("b2b3",     int'(prev3 != 0 && grt3 != 0 && prev3 != grt3), 0);
   endtask

   typedef struct packed {
      logic [3:0] req;
      logic [3:0] grt;
      logic [1:0] own;
      logic       pre;
   } vec_t;

   vec_t tbl [14];

   initial begin
      tbl[0]  = '{4'b0011, 4'b0001, 2'd0, 1'b0};
      tbl[1]  = '{4'b0011, 4'b0001, 2'd0, 1'b0};
      tbl[2]  = '{4'b0010, 4'b0000, 2'd0, 1'b0};
      tbl[3]  = '{4'b0010, 4'b0010, 2'd1, 1'b0};
      tbl[4]  = '{4'b0000, 4'b0000, 2'd1, 1'b0};
      tbl[5]  = '{4'b0000, 4'b0000, 2'd1, 1'b0};
      tbl[6]  = '{4'b0010, 4'b0010, 2'd1, 1'b0};
      tbl[7]  = '{4'b0110, 4'b0010, 2'd1, 1'b0};
      tbl[8]  = '{4'b0110, 4'b0010, 2'd1, 1'b0};
      tbl[9]  = '{4'b0110, 4'b0010, 2'd1, 1'b0};
      tbl[10] = '{4'b0110, 4'b0000, 2'd1, 1'b1};
      tbl[11] = '{4'b0110, 4'b0100, 2'd2, 1'b0};
      tbl[12] = '{4'b0100, 4'b0100, 2'd2, 1'b0};
      tbl[13] = '{4'b0000, 4'b0000, 2'd2, 1'b0};

      do_reset();
      chk("rst_grt",   int'(grt4),  0);
      chk("rst_busy",  int'(busy4), 0);
      chk("rst_pre",   int'(pre4),  0);
      chk("rst_owner", int'(own4),  0);

      for (int i = 0; i < 14; i++) begin
         req4 = tbl[i].req;
         tick();
         chk($sformatf("tbl%0d_grt", i),   int'(grt4),  int'(tbl[i].grt));
         chk($sformatf("tbl%0d_owner", i), int'(own4),  int'(tbl[i].own));
         chk($sformatf("tbl%0d_pre", i),   int'(pre4),  int'(tbl[i].pre));
         chk($sformatf("tbl%0d_busy", i),  int'(busy4), int'(tbl[i].grt != 4'b0));
      end

      // Lone requester is never preempted.
      do_reset();
      req4 = 4'b1000;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("solo_grt", int'(grt4), 8);
         chk("solo_pre", int'(pre4), 0);
      end

      // Asynchronous reset withdraws a live grant without a clock edge.
      do_reset();
      req4 = 4'b0100;
      tick();
      chk("areset_pre_grt", int'(grt4), 4);
      #2 Rst = 1'b1;
      m4 = mdl_reset(4);
      m3 = mdl_reset(3);
      #1;
      chk("areset_grt",   int'(grt4),  0);
      chk("areset_busy",  int'(busy4), 0);
      chk("areset_owner", int'(own4),  0);
      req4 = 4'b0101;
      @(posedge Clk);
      #2 Rst = 1'b0;
      tick();
      chk("areset_resume", int'(grt4), 1);

      // Three channels rotating with a one-cycle turnaround between owners.
      do_reset();
      req3 = 3'b111;
      tick();
      for (int g = 0; g < 4; g++) begin
         chk("rr3_grant", int'(grt3), 1 << (g % 3));
         tick();
         chk("rr3_hold", int'(grt3), 1 << (g % 3));
         req3 = 3'b111 & ~(3'b001 << (g % 3));
         tick();
         chk("rr3_gap", int'(grt3), 0);
         req3 = 3'b111;
         tick();
      end

      do_reset();
      for (int i = 0; i < 4000; i++) begin
         for (int c = 0; c < 4; c++)
            if ($urandom_range(0, 5) == 0) req4[c] = ~req4[c];
         for (int c = 0; c < 3; c++)
            if ($urandom_range(0, 5) == 0) req3[c] = ~req3[c];
         tick();
         compare_model();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
